layer_loader: RTL and testbench
===============================

LAYER_LOADER -- requirements
Module: layer_loader

Interface
REQ-001 SHALL take parameters: DATA_WIDTH, default 32, word width; ADDR_WIDTH, default 18, DRAM/source word-address width; NUM_PHASES, default 8, phase 0 = image, phases 1..7 = l0_pre, l0_post, l1, l2_pre, l2_post, l3, l4_l5.
REQ-002 SHALL have ports, one per line as name, direction, width, meaning:
  clk  in  1  single clock, all logic on rising edge
  srst  in  1  synchronous, active-high reset
  start  in  1  one-cycle request to run the full load sequence
  src_en_rd  out  1  source read request
  src_addr_rd  out  ADDR_WIDTH  source read address
  src_valid  in  1  source read data valid; in-order, latency >= 1
  src_data  in  DATA_WIDTH  source read data
  dram_en_wr  out  1  DRAM write strobe
  dram_addr_wr  out  ADDR_WIDTH  DRAM write address
  dram_data_wr  out  DATA_WIDTH  DRAM write data
  enable  out  1  one-cycle start pulse to lenet
  rdy_data  out  1  one-cycle "layer parameters loaded" pulse to lenet
  done_one_layer  in  1  lenet layer-complete level
  done  in  1  lenet network-complete level
  busy  out  1  sequence in progress
  finished  out  1  sticky: sequence complete
  phase  out  3  current phase index

Function
REQ-003 SHALL read per-phase descriptors {src_base, dst_base, count} (count 0..2^ADDR_WIDTH-1) from phase_desc_rom, combinationally indexed by phase.
REQ-004 SHALL implement FSM states IDLE, COPY, ENABLE, RDY, WAIT_LAYER, WAIT_DONE, FINISH.
REQ-005 IDLE: on start, SHALL set phase=0, busy=1, go to COPY; start in any other state SHALL be ignored.
REQ-006 COPY: SHALL assert src_en_rd on consecutive cycles at src_base+i for i=0..count-1 (one read per cycle, no stalls).
REQ-007 COPY: on each src_valid SHALL assert dram_en_wr for exactly that cycle with dram_data_wr=src_data, dram_addr_wr=dst_base+j, j = received-word count; write lags valid by 0 cycles (combinational pass-through, registered address counter).
REQ-008 COPY SHALL end the cycle after the count-th src_valid; count=0 SHALL skip the copy (no reads, no writes) and leave COPY after 1 cycle.
REQ-009 src_valid while issued==received SHALL be ignored (no write).
REQ-010 Exiting COPY: phase 0 -> ENABLE; phase >= 1 -> RDY.
REQ-011 ENABLE: enable=1 exactly one cycle, then phase<=1, then COPY.
REQ-012 RDY: rdy_data=1 exactly one cycle; then WAIT_LAYER if phase < NUM_PHASES-1, else WAIT_DONE.
REQ-013 WAIT_LAYER: SHALL advance on a rising edge of done_one_layer (registered previous value, 0 at reset); phase increments; next state COPY; a level held high from a prior layer SHALL NOT advance.
REQ-014 WAIT_DONE: on done=1 SHALL go to FINISH; done outside WAIT_DONE SHALL be ignored.
REQ-015 FINISH: busy=0, finished=1 held until reset or next start (start clears finished and begins phase 0).
REQ-016 Address arithmetic SHALL be modulo 2^ADDR_WIDTH (wrap, no error).
REQ-017 enable, rdy_data, src_en_rd, dram_en_wr SHALL never be high in the same cycle as enable or rdy_data respectively overlapping another control pulse (control pulses mutually exclusive).

Reset
REQ-018 srst=1 at any cycle, including mid-COPY, SHALL force state IDLE, phase=0, all counters 0, all outputs 0 at the next edge; in-flight src_valid after reset SHALL be ignored.

Structure
REQ-019 Shared package lenet_pkg SHALL hold DATA_WIDTH, ADDR_WIDTH, NUM_PHASES, the FSM state enum and the descriptor struct.
REQ-020 Descriptor table SHALL be one sub-module phase_desc_rom (input phase, output descriptor); copy counters and FSM stay in layer_loader.

Verification
REQ-021 Phase 0 desc {0,0,4}, source latency 2, data 0xA0..0xA3 -> writes at DRAM 0..3 in order, then enable pulse 1 cycle, then phase=1.
REQ-022 Full run with each layer's done_one_layer raised 10 cycles after rdy_data -> exactly 7 rdy_data pulses, 1 enable, phase 0..7, finished=1 after done.
REQ-023 Phase 3 count=0 -> no src_en_rd/dram_en_wr in phase 3, rdy_data one cycle after entering COPY.
REQ-024 done_one_layer held high across rdy_data of next layer -> no advance until low then high again.
REQ-025 srst asserted mid-COPY with 2 reads outstanding -> next cycle all outputs 0, late src_valid produces no write; subsequent start restarts at phase 0.
REQ-026 dst_base=0x3FFFE, count=4 -> writes at 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared types and constants for the LeNet parameter loader.
package lenet_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 18;
    localparam int NUM_PHASES = 8;
    localparam int PHASE_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COPY,
        ST_ENABLE,
        ST_RDY,
        ST_WAIT_LAYER,
        ST_WAIT_DONE,
        ST_FINISH
    } state_e;

    // One copy job: count words from src_base to dst_base.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] src_base;
        logic [ADDR_WIDTH-1:0] dst_base;
        logic [ADDR_WIDTH-1:0] count;
    } phase_desc_t;

    function automatic phase_desc_t mk_desc(input logic [ADDR_WIDTH-1:0] s,
                                            input logic [ADDR_WIDTH-1:0] d,
                                            input logic [ADDR_WIDTH-1:0] c);
        phase_desc_t r;
        r.src_base = s;
        r.dst_base = d;
        r.count    = c;
        return r;
    endfunction

endpackage

// File: rtl/phase_desc_rom.sv
// Per-phase copy descriptors: phase 0 is the input image, phases 1..7 are layer parameters.
module phase_desc_rom
    import lenet_pkg::*;
(
    input  logic [PHASE_W-1:0] phase,
    output phase_desc_t        desc
);

    // Constant lookup; phase 3 is intentionally empty and phase 4/7 exercise address wrap.
    always_comb begin
        desc = mk_desc('0, '0, '0);
        case (phase)
            3'd0: desc = mk_desc(18'h00000, 18'h00000, 18'd4);
            3'd1: desc = mk_desc(18'h00100, 18'h00010, 18'd3);
            3'd2: desc = mk_desc(18'h00200, 18'h00020, 18'd2);
            3'd3: desc = mk_desc(18'h00300, 18'h00030, 18'd0);
            3'd4: desc = mk_desc(18'h00400, 18'h3FFFE, 18'd4);
            3'd5: desc = mk_desc(18'h00500, 18'h00050, 18'd1);
            3'd6: desc = mk_desc(18'h00600, 18'h00060, 18'd5);
            3'd7: desc = mk_desc(18'h3FFFF, 18'h00070, 18'd3);
            default: desc = mk_desc('0, '0, '0);
        endcase
    end

endmodule

// File: rtl/layer_loader.sv
// Sequences the image and layer-parameter copies into DRAM and handshakes with lenet.
module layer_loader
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH = lenet_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = lenet_pkg::ADDR_WIDTH,
    parameter int NUM_PHASES = lenet_pkg::NUM_PHASES
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  start,
    output logic                  src_en_rd,
    output logic [ADDR_WIDTH-1:0] src_addr_rd,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  dram_en_wr,
    output logic [ADDR_WIDTH-1:0] dram_addr_wr,
    output logic [DATA_WIDTH-1:0] dram_data_wr,
    output logic                  enable,
    output logic                  rdy_data,
    input  logic                  done_one_layer,
    input  logic                  done,
    output logic                  busy,
    output logic                  finished,
    output logic [2:0]            phase
);

    state_e                state_q, state_d;
    logic [2:0]            phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] issued_q, issued_d;
    logic [ADDR_WIDTH-1:0] received_q, received_d;
    logic                  dl_prev_q, dl_prev_d;
    logic                  layer_rise;
    phase_desc_t           desc;

    phase_desc_rom u_rom (
        .phase (phase_q),
        .desc  (desc)
    );

    assign layer_rise = done_one_layer & ~dl_prev_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign finished   = (state_q == ST_FINISH);
    assign phase      = phase_q;

    // Next-state, copy counters and one-cycle control pulses.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        issued_d     = issued_q;
        received_d   = received_q;
        dl_prev_d    = done_one_layer;
        src_en_rd    = 1'b0;
        src_addr_rd  = '0;
        dram_en_wr   = 1'b0;
        dram_addr_wr = '0;
        dram_data_wr = '0;
        enable       = 1'b0;
        rdy_data     = 1'b0;
        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    phase_d    = 3'd0;
                    issued_d   = '0;
                    received_d = '0;
                    state_d    = ST_COPY;
                end
            end
            ST_COPY: begin
                if (received_q == desc.count) begin
                    issued_d   = '0;
                    received_d = '0;
                    state_d    = (phase_q == 3'd0) ? ST_ENABLE : ST_RDY;
                end else begin
                    if (issued_q != desc.count) begin
                        src_en_rd   = 1'b1;
                        src_addr_rd = desc.src_base + issued_q;
                        issued_d    = issued_q + 1'b1;
                    end
                    // Returns with nothing outstanding are stale and dropped.
                    if (src_valid && (issued_q != received_q)) begin
                        dram_en_wr   = 1'b1;
                        dram_addr_wr = desc.dst_base + received_q;
                        dram_data_wr = src_data;
                        received_d   = received_q + 1'b1;
                    end
                end
            end
            ST_ENABLE: begin
                enable  = 1'b1;
                phase_d = 3'd1;
                state_d = ST_COPY;
            end
            ST_RDY: begin
                rdy_data = 1'b1;
                state_d  = (phase_q < 3'(NUM_PHASES - 1)) ? ST_WAIT_LAYER : ST_WAIT_DONE;
            end
            ST_WAIT_LAYER: begin
                if (layer_rise) begin
                    phase_d = phase_q + 1'b1;
                    state_d = ST_COPY;
                end
            end
            ST_WAIT_DONE: begin
                if (done) begin
                    state_d = ST_FINISH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= ST_IDLE;
            phase_q    <= 3'd0;
            issued_q   <= '0;
            received_q <= '0;
            dl_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            dl_prev_q  <= dl_prev_d;
        end
    end

endmodule

// File: tb/tb_layer_loader.sv
// Randomized scoreboard bench for layer_loader.
module tb_layer_loader;

    logic        clk = 1'b0;
    logic        srst, start, src_valid, done_one_layer, done;
    logic [31:0] src_data;
    logic        src_en_rd, dram_en_wr, enable, rdy_data, busy, finished;
    logic [17:0] src_addr_rd, dram_addr_wr;
    logic [31:0] dram_data_wr;
    logic [2:0]  phase;

    layer_loader dut (
        .clk(clk), .srst(srst), .start(start),
        .src_en_rd(src_en_rd), .src_addr_rd(src_addr_rd),
        .src_valid(src_valid), .src_data(src_data),
        .dram_en_wr(dram_en_wr), .dram_addr_wr(dram_addr_wr), .dram_data_wr(dram_data_wr),
        .enable(enable), .rdy_data(rdy_data),
        .done_one_layer(done_one_layer), .done(done),
        .busy(busy), .finished(finished), .phase(phase)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    // Reference descriptor table.
    logic [17:0] t_src [8] = '{18'h00000, 18'h00100, 18'h00200, 18'h00300,
                               18'h00400, 18'h00500, 18'h00600, 18'h3FFFF};
    logic [17:0] t_dst [8] = '{18'h00000, 18'h00010, 18'h00020, 18'h00030,
                               18'h3FFFE, 18'h00050, 18'h00060, 18'h00070};
    int          t_cnt [8] = '{4, 3, 2, 0, 4, 1, 5, 3};

    logic [31:0] seed;

    function automatic logic [31:0] srcval(input logic [17:0] a);
        if (a < 18'd4) return 32'hA0 + {14'd0, a};
        return {a[7:0], 6'b0, a} ^ seed;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: unexpected or missing event (cycle %0d)", name, cyc);
    endtask

    // Scoreboard queues.
    typedef struct {
        int          kind;   // 0 write, 1 enable, 2 rdy_data
        logic [17:0] a;
        logic [31:0] d;
        int          ph;
    } ev_t;
    ev_t         exp_ev[$];
    logic [17:0] exp_rd[$];

    task automatic push_run();
        logic [17:0] a;
        ev_t e;
        for (int p = 0; p < 8; p++) begin
            for (int j = 0; j < t_cnt[p]; j++) begin
                a = t_src[p] + 18'(j);
                exp_rd.push_back(a);
                e.kind = 0;
                e.a    = t_dst[p] + 18'(j);
                e.d    = srcval(a);
                e.ph   = p;
                exp_ev.push_back(e);
            end
            e.kind = (p == 0) ? 1 : 2;
            e.a    = '0;
            e.d    = '0;
            e.ph   = p;
            exp_ev.push_back(e);
        end
    endtask

    // Source memory model: in-order returns after lat cycles.
    typedef struct {
        int          due;
        logic [17:0] a;
    } rq_t;
    rq_t pend[$];
    int  lat = 2;

    always @(posedge clk) begin
        rq_t r;
        #1;
        if (src_en_rd === 1'b1) pend.push_back('{cyc + lat, src_addr_rd});
        src_valid = 1'b0;
        src_data  = $urandom;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            src_valid = 1'b1;
            src_data  = srcval(r.a);
        end
    end

    // Monitor: compare every DUT event against the scoreboard.
    bit mon_on   = 0;
    bit prev_en  = 0;
    bit prev_rdy = 0;
    int n_en     = 0;
    int n_rdy    = 0;
    int t3       = -100;
    int last_ph  = 0;

    always @(negedge clk) begin
        ev_t e;
        if (mon_on) begin
            if (prev_en) begin
                chk("en_one_cycle", enable, 0);
                chk("phase_after_en", phase, 1);
            end
            if (prev_rdy) chk("rdy_one_cycle", rdy_data, 0);
            if (phase == 3'd3 && last_ph != 3) t3 = cyc;
            last_ph = phase;
            if (src_en_rd) begin
                if (exp_rd.size() == 0) fail_now("rd_unexpected");
                else chk("rd_addr", src_addr_rd, exp_rd.pop_front());
            end
            if (dram_en_wr) begin
                if (exp_ev.size() == 0) fail_now("wr_unexpected");
                else begin
                    e = exp_ev.pop_front();
                    chk("wr_kind", 0, e.kind);
                    chk("wr_addr", dram_addr_wr, e.a);
                    chk("wr_data", dram_data_wr, e.d);
                end
            end
            if (enable) begin
                n_en++;
                if (exp_ev.size() == 0) fail_now("en_unexpected");
                else begin
                    e = exp_ev.pop_front();
                    chk("en_kind", 1, e.kind);
                    chk("en_phase", phase, e.ph);
                end
            end
            if (rdy_data) begin
                n_rdy++;
                if (phase == 3'd3) chk("p3_rdy_latency", cyc - t3, 1);
                if (exp_ev.size() == 0) fail_now("rdy_unexpected");
                else begin
                    e = exp_ev.pop_front();
                    chk("rdy_kind", 2, e.kind);
                    chk("rdy_phase", phase, e.ph);
                end
            end
            if (enable || rdy_data)
                chk("pulse_exclusive", 32'(enable) + 32'(rdy_data) + 32'(src_en_rd | dram_en_wr), 1);
            prev_en  = enable;
            prev_rdy = rdy_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_layers(input bit sticky, input int dly, input bit noise);
        bit got;
        for (int p = 1; p <= 7; p++) begin
            got = 0;
            for (int i = 0; i < 3000 && !got; i++) begin
                @(negedge clk);
                got = rdy_data;
            end
            if (!got) begin
                fail_now("rdy_timeout");
                return;
            end
            if (noise && p == 3) begin
                step();
                done  = 1'b1;
                start = 1'b1;
                step();
                done  = 1'b0;
                start = 1'b0;
            end
            if (p < 7) begin
                if (sticky && done_one_layer) begin
                    repeat (dly) step();
                    chk("held_level_no_advance", phase, p);
                    step();
                    done_one_layer = 1'b0;
                    step();
                    done_one_layer = 1'b1;
                end else begin
                    repeat (dly) step();
                    done_one_layer = 1'b1;
                    if (!sticky) begin
                        step();
                        done_one_layer = 1'b0;
                    end
                end
            end else begin
                repeat (dly) step();
                chk("finished_before_done", finished, 0);
                done = 1'b1;
            end
        end
    endtask

    task automatic run_full(input bit sticky, input int dly, input bit noise);
        push_run();
        n_en  = 0;
        n_rdy = 0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_clears_finished", finished, 0);
        chk("start_phase0", phase, 0);
        drive_layers(sticky, dly, noise);
        for (int i = 0; i < 50 && finished !== 1'b1; i++) step();
        chk("finished", finished, 1);
        done           = 1'b0;
        done_one_layer = 1'b0;
        chk("final_busy", busy, 0);
        chk("final_phase", phase, 7);
        chk("rdy_count", n_rdy, 7);
        chk("enable_count", n_en, 1);
        chk("events_left", exp_ev.size(), 0);
        chk("reads_left", exp_rd.size(), 0);
        repeat (5) step();
        chk("finished_sticky", finished, 1);
    endtask

    task automatic reset_mid_copy();
        lat = 3;
        for (int j = 0; j < t_cnt[0]; j++) exp_rd.push_back(t_src[0] + 18'(j));
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        srst = 1'b1;
        step();
        srst = 1'b0;
        @(negedge clk);
        chk("rst_src_en", src_en_rd, 0);
        chk("rst_src_addr", src_addr_rd, 0);
        chk("rst_wr_en", dram_en_wr, 0);
        chk("rst_wr_addr", dram_addr_wr, 0);
        chk("rst_wr_data", dram_data_wr, 0);
        chk("rst_enable", enable, 0);
        chk("rst_rdy", rdy_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_phase", phase, 0);
        exp_rd.delete();
        exp_ev.delete();
        repeat (8) step();
        chk("rst_idle_busy", busy, 0);
        chk("rst_pending_drained", pend.size(), 0);
    endtask

    initial begin
        srst = 1'b1;
        start = 1'b0;
        done_one_layer = 1'b0;
        done = 1'b0;
        src_valid = 1'b0;
        src_data = '0;
        seed = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_finished", finished, 0);
        chk("reset_phase", phase, 0);
        chk("reset_src_en", src_en_rd, 0);
        chk("reset_wr_en", dram_en_wr, 0);
        chk("reset_pulses", {enable, rdy_data}, 0);
        step();
        srst = 1'b0;
        mon_on = 1;

        lat = 2;
        run_full(1'b0, 10, 1'b0);

        lat = $urandom_range(1, 4);
        run_full(1'b1, $urandom_range(3, 8), 1'b1);

        reset_mid_copy();

        lat = $urandom_range(1, 4);
        run_full(1'b0, $urandom_range(3, 12), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
